// File: rtl/clink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clink_pkg
// Description : Shared types, constants and the 7-bit rotate helper for the
//               Camera Link word aligner.
// Revision    : 1.0 - initial release
// ============================================================================
package clink_pkg;

    localparam int CLINK_WORD_W = 7;

    // Control-bit positions inside the aligned word of the control lane
    localparam int LVAL_BIT  = 3;
    localparam int FVAL_BIT  = 4;
    localparam int DVAL_BIT  = 5;
    localparam int CTRL_LANE = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } clink_state_t;

    // Rotate a 7-bit word left by r (0..6). The upper half of the doubled
    // word after shifting is exactly the rotated value.
    function automatic logic [CLINK_WORD_W-1:0] rotl7(
        input logic [CLINK_WORD_W-1:0] w,
        input logic [2:0]              r
    );
        logic [2*CLINK_WORD_W-1:0] w_dbl;
        w_dbl = {w, w} << r;
        return w_dbl[2*CLINK_WORD_W-1:CLINK_WORD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/clink_lane_rotator.sv
`default_nettype none
// ============================================================================
// Module      : clink_lane_rotator
// Description : Registered 7-bit rotation of one deserialized data lane.
//               Output holds its value when i_en is low.
// Revision    : 1.0 - initial release
// ============================================================================
module clink_lane_rotator
    import clink_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic [2:0]              i_rot,
    input  logic [CLINK_WORD_W-1:0] i_word,
    output logic [CLINK_WORD_W-1:0] o_word
);

    logic [CLINK_WORD_W-1:0] r_word;

    // Capture the rotated lane word on qualified cycles only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
        end else if (i_en) begin
            r_word <= rotl7(i_word, i_rot);
        end
    end

    assign o_word = r_word;

endmodule
`default_nettype wire

// File: rtl/clink_word_aligner.sv
`default_nettype none
// ============================================================================
// Module      : clink_word_aligner
// Description : Camera Link 7:1 word aligner and lock detector. Searches the
//               clock-lane rotation, tracks lock, realigns all data lanes and
//               extracts LVAL/FVAL/DVAL with frame/line start strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module clink_word_aligner
    import clink_pkg::*;
#(
    parameter int         NUM_LANES     = 4,
    parameter logic [6:0] CLK_PATTERN   = 7'b1100011,
    parameter int         LOCK_COUNT    = 64,
    parameter int         UNLOCK_ERRORS = 4
) (
    input  logic                              s_axi_aclk,
    input  logic                              s_axi_areset,
    input  logic                              enable,
    input  logic                              word_valid,
    input  logic [CLINK_WORD_W-1:0]           clk_word,
    input  logic [NUM_LANES*CLINK_WORD_W-1:0] data_words,
    output logic                              locked,
    output logic [2:0]                        rotation,
    output logic                              lock_lost,
    output logic [15:0]                       err_count,
    output logic                              pix_valid,
    output logic [NUM_LANES*CLINK_WORD_W-1:0] pix_data,
    output logic                              lval,
    output logic                              fval,
    output logic                              dval,
    output logic                              frame_start,
    output logic                              line_start
);

    clink_state_t r_state, w_state_nxt;
    logic [2:0]   r_rot, w_rot_nxt;
    logic [15:0]  r_match_cnt, w_match_nxt;
    logic [7:0]   r_err_run, w_err_run_nxt;
    logic [15:0]  r_err_count, w_err_count_nxt;
    logic         r_lock_lost, w_lock_lost_nxt;
    logic         r_pix_valid;
    logic         r_lval, r_fval, r_dval;
    logic         r_frame_start, r_line_start;

    logic                    w_match;
    logic                    w_pix_load;
    logic [CLINK_WORD_W-1:0] w_ctrl_word;

    assign w_match     = (rotl7(clk_word, r_rot) == CLK_PATTERN);
    assign w_pix_load  = word_valid && (r_state == LOCKED);
    assign w_ctrl_word = rotl7(data_words[CTRL_LANE*CLINK_WORD_W +: CLINK_WORD_W], r_rot);

    // State, rotation and counter registers
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_state     <= IDLE;
            r_rot       <= '0;
            r_match_cnt <= '0;
            r_err_run   <= '0;
            r_err_count <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rot       <= w_rot_nxt;
            r_match_cnt <= w_match_nxt;
            r_err_run   <= w_err_run_nxt;
            r_err_count <= w_err_count_nxt;
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    // Next-state logic; enable low overrides any same-cycle event
    always_comb begin
        w_state_nxt     = r_state;
        w_rot_nxt       = r_rot;
        w_match_nxt     = r_match_cnt;
        w_err_run_nxt   = r_err_run;
        w_err_count_nxt = r_err_count;
        w_lock_lost_nxt = 1'b0;
        if (!enable) begin
            w_state_nxt   = IDLE;
            w_match_nxt   = '0;
            w_err_run_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt   = SEARCH;
                    w_match_nxt   = '0;
                    w_err_run_nxt = '0;
                end
                SEARCH: begin
                    if (word_valid) begin
                        if (w_match) begin
                            if (r_match_cnt == 16'(LOCK_COUNT - 1)) begin
                                w_state_nxt   = LOCKED;
                                w_match_nxt   = '0;
                                w_err_run_nxt = '0;
                            end else begin
                                w_match_nxt = r_match_cnt + 16'd1;
                            end
                        end else begin
                            w_match_nxt = '0;
                            w_rot_nxt   = (r_rot == 3'd6) ? 3'd0 : r_rot + 3'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (word_valid) begin
                        if (w_match) begin
                            w_err_run_nxt = '0;
                        end else begin
                            if (r_err_count != 16'hFFFF) begin
                                w_err_count_nxt = r_err_count + 16'd1;
                            end
                            if (r_err_run == 8'(UNLOCK_ERRORS - 1)) begin
                                w_state_nxt     = SEARCH;
                                w_lock_lost_nxt = 1'b1;
                                w_err_run_nxt   = '0;
                                w_match_nxt     = '0;
                            end else begin
                                w_err_run_nxt = r_err_run + 8'd1;
                            end
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Control bits follow aligned lane data while locked; strobes mark rising edges
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_pix_valid   <= 1'b0;
            r_lval        <= 1'b0;
            r_fval        <= 1'b0;
            r_dval        <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_pix_valid   <= w_pix_load;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            if (w_state_nxt != LOCKED) begin
                r_lval <= 1'b0;
                r_fval <= 1'b0;
                r_dval <= 1'b0;
            end else if (w_pix_load) begin
                r_lval        <= w_ctrl_word[LVAL_BIT];
                r_fval        <= w_ctrl_word[FVAL_BIT];
                r_dval        <= w_ctrl_word[DVAL_BIT];
                r_frame_start <= w_ctrl_word[FVAL_BIT] & ~r_fval;
                r_line_start  <= w_ctrl_word[LVAL_BIT] & ~r_lval;
            end
        end
    end

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        clink_lane_rotator u_rot (
            .clk    (s_axi_aclk),
            .rst    (s_axi_areset),
            .i_en   (w_pix_load),
            .i_rot  (r_rot),
            .i_word (data_words[n*CLINK_WORD_W +: CLINK_WORD_W]),
            .o_word (pix_data[n*CLINK_WORD_W +: CLINK_WORD_W])
        );
    end

    assign locked      = (r_state == LOCKED);
    assign rotation    = r_rot;
    assign lock_lost   = r_lock_lost;
    assign err_count   = r_err_count;
    assign pix_valid   = r_pix_valid;
    assign lval        = r_lval;
    assign fval        = r_fval;
    assign dval        = r_dval;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;

endmodule
`default_nettype wire

// File: tb/tb_clink_word_aligner.sv
`default_nettype none
// ============================================================================
// Module      : tb_clink_word_aligner
// Description : Directed self-checking bench for clink_word_aligner (Base and
//               Full configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clink_word_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad = 0;

    // Base configuration DUT
    logic        enable = 1'b0, wv = 1'b0;
    logic [6:0]  cw = '0;
    logic [27:0] dw = '0;
    logic        locked, lock_lost, pix_valid, lval, fval, dval, frame_start, line_start;
    logic [2:0]  rotation;
    logic [15:0] err_count;
    logic [27:0] pix_data;

    // Full configuration DUT
    logic        f_en = 1'b0, f_wv = 1'b0;
    logic [6:0]  f_cw = '0;
    logic [83:0] f_dw = '0;
    logic        f_locked, f_lock_lost, f_pix_valid, f_lval, f_fval, f_dval, f_fs, f_ls;
    logic [2:0]  f_rotation;
    logic [15:0] f_err_count;
    logic [83:0] f_pix_data;

    always #5 clk = ~clk;

    clink_word_aligner #(.NUM_LANES(4)) u_dut (
        .s_axi_aclk(clk), .s_axi_areset(rst), .enable(enable), .word_valid(wv),
        .clk_word(cw), .data_words(dw), .locked(locked), .rotation(rotation),
        .lock_lost(lock_lost), .err_count(err_count), .pix_valid(pix_valid),
        .pix_data(pix_data), .lval(lval), .fval(fval), .dval(dval),
        .frame_start(frame_start), .line_start(line_start)
    );

    clink_word_aligner #(.NUM_LANES(12), .LOCK_COUNT(4)) u_full (
        .s_axi_aclk(clk), .s_axi_areset(rst), .enable(f_en), .word_valid(f_wv),
        .clk_word(f_cw), .data_words(f_dw), .locked(f_locked), .rotation(f_rotation),
        .lock_lost(f_lock_lost), .err_count(f_err_count), .pix_valid(f_pix_valid),
        .pix_data(f_pix_data), .lval(f_lval), .fval(f_fval), .dval(f_dval),
        .frame_start(f_fs), .line_start(f_ls)
    );

    function automatic logic [6:0] rotl(input logic [6:0] w, input int r);
        int x;
        x = int'(w);
        return 7'(((x << r) | (x >> (7 - r))) & 127);
    endfunction

    function automatic logic [6:0] rotr(input logic [6:0] w, input int r);
        int x;
        x = int'(w);
        return 7'(((x >> r) | (x << (7 - r))) & 127);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic v, input logic [6:0] c, input logic [27:0] d);
        wv = v; cw = c; dw = d;
        tick();
    endtask

    task automatic feed_full(input logic v, input logic [6:0] c, input logic [83:0] d);
        f_wv = v; f_cw = c; f_dw = d;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if ({locked, lock_lost, pix_valid, lval, fval, dval, frame_start, line_start} !== 8'h00) begin
            bad++; $display("FAIL reset_flags got=%b want=00000000", {locked, lock_lost, pix_valid, lval, fval, dval, frame_start, line_start}); end
        total++; if (rotation !== 3'd0 || err_count !== 16'd0 || pix_data !== 28'd0) begin
            bad++; $display("FAIL reset_vals got rot=%0d err=%0d pix=%h want 0", rotation, err_count, pix_data); end
        total++; if (f_locked !== 1'b0 || f_pix_data !== 84'd0) begin
            bad++; $display("FAIL reset_full got locked=%b pix=%h want 0", f_locked, f_pix_data); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lock_acq();
        logic [6:0] w;
        w = rotr(7'h63, 3);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            feed(1'b1, w, 28'd0);
            total++; if (rotation !== 3'(i + 1)) begin
                bad++; $display("FAIL rot_step%0d got=%0d want=%0d", i, rotation, i + 1); end
        end
        for (int i = 0; i < 64; i++) begin
            feed(1'b1, w, 28'd0);
            if (i == 62) begin
                total++; if (locked !== 1'b0) begin
                    bad++; $display("FAIL lock_early got=%b want=0", locked); end
            end
        end
        total++; if (locked !== 1'b1) begin
            bad++; $display("FAIL lock_acq got=%b want=1", locked); end
        total++; if (rotation !== 3'd3) begin
            bad++; $display("FAIL lock_rot got=%0d want=3", rotation); end
        total++; if (pix_valid !== 1'b0) begin
            bad++; $display("FAIL lock_pixv got=%b want=0", pix_valid); end
    endtask

    task automatic test_data_align();
        logic [27:0] d;
        d = {rotr(7'h18, 3), 7'd0, 7'd0, rotr(7'h2A, 3)};
        feed(1'b1, rotr(7'h63, 3), d);
        total++; if (pix_valid !== 1'b1 || pix_data[6:0] !== 7'h2A || pix_data[27:21] !== 7'h18) begin
            bad++; $display("FAIL align_data got v=%b l0=%h l3=%h want v=1 l0=2a l3=18", pix_valid, pix_data[6:0], pix_data[27:21]); end
        total++; if ({fval, lval, dval, frame_start, line_start} !== 5'b11011) begin
            bad++; $display("FAIL align_ctrl got=%b want=11011", {fval, lval, dval, frame_start, line_start}); end
        feed(1'b1, rotr(7'h63, 3), d);
        total++; if ({fval, lval, frame_start, line_start} !== 4'b1100) begin
            bad++; $display("FAIL align_once got=%b want=1100", {fval, lval, frame_start, line_start}); end
        feed(1'b0, 7'h00, 28'd0);
        total++; if (pix_valid !== 1'b0 || pix_data[6:0] !== 7'h2A || fval !== 1'b1) begin
            bad++; $display("FAIL align_hold got v=%b l0=%h f=%b want v=0 l0=2a f=1", pix_valid, pix_data[6:0], fval); end
    endtask

    task automatic test_errors();
        logic [27:0] d;
        d = {rotr(7'h18, 3), 21'd0};
        for (int i = 0; i < 3; i++) feed(1'b1, 7'h00, d);
        total++; if (locked !== 1'b1 || err_count !== 16'd3) begin
            bad++; $display("FAIL err_tol got locked=%b err=%0d want 1/3", locked, err_count); end
        feed(1'b1, rotr(7'h63, 3), d);
        total++; if (locked !== 1'b1 || err_count !== 16'd3 || frame_start !== 1'b0) begin
            bad++; $display("FAIL err_recover got locked=%b err=%0d fs=%b want 1/3/0", locked, err_count, frame_start); end
        for (int i = 0; i < 3; i++) feed(1'b1, 7'h00, d);
        total++; if (locked !== 1'b1 || lock_lost !== 1'b0) begin
            bad++; $display("FAIL err_run3 got locked=%b lost=%b want 1/0", locked, lock_lost); end
        feed(1'b1, 7'h00, d);
        total++; if (lock_lost !== 1'b1 || locked !== 1'b0 || err_count !== 16'd7 || rotation !== 3'd3) begin
            bad++; $display("FAIL unlock got lost=%b locked=%b err=%0d rot=%0d want 1/0/7/3", lock_lost, locked, err_count, rotation); end
        total++; if (fval !== 1'b0 || lval !== 1'b0) begin
            bad++; $display("FAIL unlock_ctrl got f=%b l=%b want 0/0", fval, lval); end
        feed(1'b0, 7'h00, d);
        total++; if (lock_lost !== 1'b0) begin
            bad++; $display("FAIL lost_pulse got=%b want=0", lock_lost); end
    endtask

    task automatic test_reset_midlock();
        logic [27:0] d;
        d = {rotr(7'h18, 3), 7'd0, 7'd0, rotr(7'h55, 3)};
        for (int i = 0; i < 64; i++) feed(1'b1, rotr(7'h63, 3), 28'd0);
        feed(1'b1, rotr(7'h63, 3), d);
        total++; if (locked !== 1'b1 || fval !== 1'b1 || pix_data[6:0] !== 7'h55) begin
            bad++; $display("FAIL relock got locked=%b f=%b l0=%h want 1/1/55", locked, fval, pix_data[6:0]); end
        rst = 1'b1;
        #2;
        total++; if ({locked, pix_valid, lval, fval, frame_start, line_start, lock_lost} !== 7'd0 ||
                     rotation !== 3'd0 || err_count !== 16'd0 || pix_data !== 28'd0) begin
            bad++; $display("FAIL async_rst got locked=%b f=%b rot=%0d err=%0d pix=%h want 0", locked, fval, rotation, err_count, pix_data); end
        enable = 1'b0;
        wv = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_valid_gaps();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) begin
            feed(1'b1, 7'h63, 28'd0);
            if (i == 62) begin
                total++; if (locked !== 1'b0) begin
                    bad++; $display("FAIL gap_early got=%b want=0", locked); end
            end
            feed(1'b0, 7'h00, 28'd0);
            if (i == 62) begin
                total++; if (locked !== 1'b0) begin
                    bad++; $display("FAIL gap_idle got=%b want=0", locked); end
            end
        end
        total++; if (locked !== 1'b1 || rotation !== 3'd0) begin
            bad++; $display("FAIL gap_lock got locked=%b rot=%0d want 1/0", locked, rotation); end
        feed(1'b1, 7'h63, 28'h0000011);
        total++; if (pix_valid !== 1'b1 || pix_data[6:0] !== 7'h11) begin
            bad++; $display("FAIL gap_pixv got v=%b l0=%h want 1/11", pix_valid, pix_data[6:0]); end
        feed(1'b0, 7'h63, 28'h0000022);
        total++; if (pix_valid !== 1'b0 || pix_data[6:0] !== 7'h11) begin
            bad++; $display("FAIL gap_nopix got v=%b l0=%h want 0/11", pix_valid, pix_data[6:0]); end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        tick();
        total++; if (locked !== 1'b0) begin
            bad++; $display("FAIL en_drop got=%b want=0", locked); end
        enable = 1'b1;
        tick();
        for (int i = 0; i < 63; i++) feed(1'b1, 7'h63, 28'd0);
        enable = 1'b0;
        feed(1'b1, 7'h63, 28'd0);
        total++; if (locked !== 1'b0) begin
            bad++; $display("FAIL en_beats_lock got=%b want=0", locked); end
        enable = 1'b1;
        tick();
        feed(1'b1, 7'h63, 28'd0);
        total++; if (locked !== 1'b0) begin
            bad++; $display("FAIL en_cnt_clear got=%b want=0", locked); end
        enable = 1'b0;
        wv = 1'b0;
    endtask

    task automatic test_full();
        logic [83:0] d;
        logic [6:0]  v;
        f_en = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) feed_full(1'b1, rotr(7'h63, 6), 84'd0);
        total++; if (f_rotation !== 3'd6 || f_locked !== 1'b0) begin
            bad++; $display("FAIL full_search got rot=%0d locked=%b want 6/0", f_rotation, f_locked); end
        for (int i = 0; i < 4; i++) feed_full(1'b1, rotr(7'h63, 6), 84'd0);
        total++; if (f_locked !== 1'b1 || f_rotation !== 3'd6) begin
            bad++; $display("FAIL full_lock got locked=%b rot=%0d want 1/6", f_locked, f_rotation); end
        for (int n = 0; n < 12; n++) begin
            v = 7'((n * 9 + 5) & 127);
            d[n*7 +: 7] = rotr(v, 6);
        end
        feed_full(1'b1, rotr(7'h63, 6), d);
        for (int n = 0; n < 12; n++) begin
            v = 7'((n * 9 + 5) & 127);
            total++; if (f_pix_data[n*7 +: 7] !== rotl(rotr(v, 6), 6) || f_pix_data[n*7 +: 7] !== v) begin
                bad++; $display("FAIL full_lane%0d got=%h want=%h", n, f_pix_data[n*7 +: 7], v); end
        end
        total++; if (f_pix_valid !== 1'b1) begin
            bad++; $display("FAIL full_pixv got=%b want=1", f_pix_valid); end
    endtask

    initial begin
        test_reset();
        test_lock_acq();
        test_data_align();
        test_errors();
        test_reset_midlock();
        test_valid_gaps();
        test_enable();
        test_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clink_word_aligner.md
# clink_word_aligner

Parametrised Camera Link 7:1 word aligner and lock detector for the camera receive path. It sits after the per-lane 7:1 deserializers and their CDC FIFO, in the `s_axi_aclk` domain. It finds the bit rotation that maps the clock lane onto the Camera Link clock pattern, declares and monitors lock (which drives `GPIO_LED_0_LS`), and rotates all data lanes by the same amount. It supports Base, Medium and Full configurations (4, 8 or 12 data lanes), and adds loss-of-lock recovery, error counting and frame/line start strobes.

## Interface
- Clocking: one clock; reset is asynchronous and active-high.

Parameters:
- `NUM_LANES`, default 4: number of data lanes; must be 4, 8 or 12.
- `CLK_PATTERN`, default 7'b1100011: expected aligned clock-lane word.
- `LOCK_COUNT`, default 64: consecutive matching words required to declare lock; range 1–65535.
- `UNLOCK_ERRORS`, default 4: consecutive mismatching words that drop lock; range 1–255.

Ports:
- `s_axi_aclk` in 1: system clock.
- `s_axi_areset` in 1: asynchronous, active-high reset.
- `enable` in 1: aligner enable; low forces IDLE.
- `word_valid` in 1: qualifies `clk_word` and `data_words` for one cycle.
- `clk_word` in 7: raw deserialized clock-lane word.
- `data_words` in NUM_LANES*7: raw data-lane words; lane n occupies bits [7n+6:7n].
- `locked` out 1: alignment locked.
- `rotation` out 3: current rotation, 0..6.
- `lock_lost` out 1: one-cycle pulse when leaving LOCKED on errors.
- `err_count` out 16: saturating count of mismatching words seen while LOCKED.
- `pix_valid` out 1: aligned data valid.
- `pix_data` out NUM_LANES*7: aligned data words.
- `lval`, `fval`, `dval` out 1 each: control bits of lane group 0.
- `frame_start`, `line_start` out 1 each: rising-edge pulses of `fval` and `lval`.

## Operation
- Rotation function: `rotl(w,r) = ((w<<r) | (w>>(7-r))) & 7'h7F`.
- A word matches when `rotl(clk_word, rotation) == CLK_PATTERN`.
- The FSM advances only on cycles with `word_valid=1`.
- IDLE:
  - Entered on reset or when `enable=0`.
  - `locked=0`, match counter cleared, error run cleared, `rotation` held.
  - Moves to SEARCH when `enable=1`.
- SEARCH:
  - On a mismatch: `rotation` wraps 6→0, otherwise increments; match counter cleared.
  - On a match: match counter increments.
  - On the `LOCK_COUNT`-th consecutive match: moves to LOCKED.
- LOCKED:
  - On a match: error run cleared.
  - On a mismatch: error run increments and `err_count` increments, saturating at 16'hFFFF.
  - When the error run reaches `UNLOCK_ERRORS`: moves to SEARCH, pulses `lock_lost`, keeps `rotation`, clears the match counter.
- Data path:
  - `pix_data` lane n = `rotl(raw lane n, rotation)`.
  - `pix_valid = word_valid & (state==LOCKED)`.
  - `pix_data` holds its value when `pix_valid=0`.
- Control bits: from aligned lane 3, `lval` = bit 3, `fval` = bit 4, `dval` = bit 5.
  - Updated only on `pix_valid`.
  - Forced to 0 whenever not LOCKED.
- `frame_start` / `line_start` pulse on the `pix_valid` cycle where `fval` / `lval` goes 0→1.
- Priority: `enable=0` beats everything, including a same-cycle mismatch or lock completion.
- Reset values: every output is 0; `rotation=0`; state IDLE.

## Timing
- Input words are registered once: every output appears 1 cycle after the qualifying `word_valid` cycle.
- `locked` rises the cycle after the `LOCK_COUNT`-th consecutive match.
- `locked` falls in the same cycle that `lock_lost` pulses.
- With `word_valid=0`, no state, counter or rotation changes, and no strobes are generated.
- When `enable` deasserts, `locked=0` the next cycle.
- Asynchronous reset mid-lock clears all outputs immediately.

## Structure
- Package `clink_pkg`:
  - FSM enum `{IDLE, SEARCH, LOCKED}`.
  - `CLINK_WORD_W = 7`.
  - `LVAL_BIT = 3`, `FVAL_BIT = 4`, `DVAL_BIT = 5`, `CTRL_LANE = 3`.
  - `rotl7` function.
- Sub-module `clink_lane_rotator`: registered per-lane 7-bit rotation, instantiated `NUM_LANES` times.

## Test plan
- Lock acquisition:
  - Stimulus: `NUM_LANES=4`, `enable=1`, continuous valid `clk_word = rotr(7'b1100011, 3)`.
  - Required: `rotation` steps 0→1→2→3 on 3 mismatches; `locked` rises after 67 valid words; `rotation=3`.
- Data alignment:
  - Stimulus: locked at `rotation=3`, lane0 raw = `rotr(7'h2A, 3)`, lane3 raw = `rotr(7'b0011000, 3)`.
  - Required: `pix_data[6:0]=7'h2A`, `fval=1`, `lval=1`, one `frame_start` pulse and one `line_start` pulse.
- Error tolerance:
  - Stimulus: while locked, 3 mismatching words then a match.
  - Required: `locked` stays 1, `err_count=3`.
  - Stimulus: then 4 consecutive mismatches.
  - Required: `lock_lost` pulse, `locked=0`, `err_count=7`, `rotation` unchanged.
- Valid gaps:
  - Stimulus: `word_valid` toggled every other cycle during SEARCH.
  - Required: lock still needs exactly 64 valid matches; `pix_valid` only on valid cycles.
- Enable and reset:
  - Stimulus: `enable=0` on the same cycle as the 64th match.
  - Required: `locked` stays 0.
  - Stimulus: `s_axi_areset` pulsed mid-lock.
  - Required: all outputs 0 immediately.
- Full configuration:
  - Stimulus: `NUM_LANES=12`, rotation 6.
  - Required: all 12 lanes realigned identically.
